// File: rtl/execute_stage_if.sv
// Decode-to-execute bundle and execute-stage writeback/memory outputs.
// master = upstream driver, slave = execute_stage.
interface execute_stage_if #(
  parameter int DATA_W = 16
);
  logic              valid_IN;
  logic              input_IN;
  logic              wren_IN;
  logic [2:0]        writeAd_IN;
  logic              ADR_MUX_IN;
  logic              write_IN;
  logic              PC_load_IN;
  logic [2:0]        cond_IN;
  logic [2:0]        op2_IN;
  logic [DATA_W-1:0] opA_IN;
  logic [DATA_W-1:0] opB_IN;
  logic [DATA_W-1:0] ext_IN;

  logic [DATA_W-1:0] result_OUT;
  logic [DATA_W-1:0] storeData_OUT;
  logic              wren_OUT;
  logic              write_OUT;
  logic              ADR_MUX_OUT;
  logic [2:0]        writeAd_OUT;
  logic              branch_OUT;
  logic [3:0]        flags_OUT;
  logic              stall_OUT;

  modport master (
    output valid_IN, input_IN, wren_IN, writeAd_IN, ADR_MUX_IN, write_IN,
           PC_load_IN, cond_IN, op2_IN, opA_IN, opB_IN, ext_IN,
    input  result_OUT, storeData_OUT, wren_OUT, write_OUT, ADR_MUX_OUT,
           writeAd_OUT, branch_OUT, flags_OUT, stall_OUT
  );

  modport slave (
    input  valid_IN, input_IN, wren_IN, writeAd_IN, ADR_MUX_IN, write_IN,
           PC_load_IN, cond_IN, op2_IN, opA_IN, opB_IN, ext_IN,
    output result_OUT, storeData_OUT, wren_OUT, write_OUT, ADR_MUX_OUT,
           writeAd_OUT, branch_OUT, flags_OUT, stall_OUT
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU, {Z,N,C,V} flag register, branch resolve/squash, writeback register.
// Define EXEC_SERIAL_SHIFT_EN for a 1-bit-per-cycle shifter that stalls upstream.
module execute_stage #(
  parameter int DATA_W = 16
) (
  input logic            CLK,
  input logic            RST,
  execute_stage_if.slave ex
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [3:0]        flg;
  } alu_t;

  typedef struct packed {
    logic              c;
    logic [DATA_W-1:0] res;
  } shf_t;

  function automatic logic [3:0] zn(input logic [DATA_W-1:0] r, input logic c, input logic v);
    return {r == '0, r[DATA_W-1], c, v};
  endfunction

  // The extra bit beyond the operand catches the last bit shifted out (0 for amount 0).
  function automatic shf_t barrel(input logic left, input logic [DATA_W-1:0] a, input logic [3:0] n);
    logic [DATA_W:0] wide;
    shf_t            s;
    if (left) begin
      wide  = {1'b0, a} << n;
      s.c   = wide[DATA_W];
      s.res = wide[DATA_W-1:0];
    end else begin
      wide  = {a, 1'b0} >> n;
      s.c   = wide[0];
      s.res = wide[DATA_W:1];
    end
    return s;
  endfunction

  function automatic alu_t alu(input logic [2:0] op, input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] b, input logic [3:0] flg);
    logic [DATA_W:0]          wide;
    logic signed [DATA_W-1:0] sa, sb, sr;
    shf_t                     s;
    alu_t                     o;
    sa = signed'(a);
    sb = signed'(b);
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        o.res = wide[DATA_W-1:0];
        sr    = signed'(o.res);
        o.flg = zn(o.res, wide[DATA_W],
                   (sa[DATA_W-1] == sb[DATA_W-1]) && (sr[DATA_W-1] != sa[DATA_W-1]));
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        o.res = wide[DATA_W-1:0];
        sr    = signed'(o.res);
        o.flg = zn(o.res, ~wide[DATA_W],
                   (sa[DATA_W-1] != sb[DATA_W-1]) && (sr[DATA_W-1] != sa[DATA_W-1]));
      end
      OP_AND: begin o.res = a & b; o.flg = zn(o.res, 1'b0, 1'b0); end
      OP_OR:  begin o.res = a | b; o.flg = zn(o.res, 1'b0, 1'b0); end
      OP_XOR: begin o.res = a ^ b; o.flg = zn(o.res, 1'b0, 1'b0); end
      OP_SLL, OP_SRL: begin
        s     = barrel(op == OP_SLL, a, b[3:0]);
        o.res = s.res;
        o.flg = zn(s.res, s.c, flg[0]);
      end
      default: begin o.res = b; o.flg = zn(b, 1'b0, 1'b0); end
    endcase
    return o;
  endfunction

  function automatic logic cond_met(input logic [2:0] c, input logic [3:0] f);
    case (c)
      3'b000:  return 1'b1;
      3'b001:  return f[3];
      3'b010:  return !f[3];
      3'b011:  return f[2];
      3'b100:  return !f[2];
      3'b101:  return f[1];
      3'b110:  return !f[1];
      default: return f[0];
    endcase
  endfunction

  logic [DATA_W-1:0] result_p1, store_p1;
  logic              wren_p1, write_p1, admux_p1, branch_p1, squash_p1;
  logic [2:0]        wad_p1;
  logic [3:0]        flags_p1;
  logic              stall, issue, taken;
  alu_t              alu_o;

`ifdef EXEC_SERIAL_SHIFT_EN
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic              stall_q;
  logic [DATA_W-1:0] acc;
  logic              start_ser;
  shf_t              step;

  assign start_ser = !RST && (state == S_IDLE) && ex.valid_IN && !squash_p1 &&
                     !ex.PC_load_IN && !ex.input_IN &&
                     (ex.op2_IN == OP_SLL || ex.op2_IN == OP_SRL) && (ex.opB_IN[3:1] != 3'b000);
  assign stall     = (state == S_SHIFT) ? stall_q : start_ser;
  assign step      = barrel(ex.op2_IN == OP_SLL, (state == S_SHIFT) ? acc : ex.opA_IN, 4'd1);

  // The final shift cycle is the one that issues; it takes the last single-bit step.
  always_comb begin
    alu_o = alu(ex.op2_IN, ex.opA_IN, ex.opB_IN, flags_p1);
    if (state == S_SHIFT) begin
      alu_o.res = step.res;
      alu_o.flg = zn(step.res, step.c, flags_p1[0]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      stall_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_ser) begin
          state   <= S_SHIFT;
          cnt     <= ex.opB_IN[3:0] - 4'd1;
          stall_q <= ex.opB_IN[3:0] > 4'd2;
        end
        default: if (!stall_q) begin
          state <= S_IDLE;
        end else begin
          cnt     <= cnt - 4'd1;
          stall_q <= cnt > 4'd2;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (start_ser || (state == S_SHIFT && stall_q)) acc <= step.res;
  end
`else
  assign stall = 1'b0;
  assign alu_o = alu(ex.op2_IN, ex.opA_IN, ex.opB_IN, flags_p1);
`endif

  assign issue = ex.valid_IN && !stall && !squash_p1;
  assign taken = ex.PC_load_IN && cond_met(ex.cond_IN, flags_p1);

  // Stage boundary: writeback/memory bundle and flag register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      result_p1 <= '0;
      store_p1  <= '0;
      wren_p1   <= 1'b0;
      write_p1  <= 1'b0;
      admux_p1  <= 1'b0;
      wad_p1    <= '0;
      branch_p1 <= 1'b0;
      squash_p1 <= 1'b0;
      flags_p1  <= '0;
    end else begin
      squash_p1 <= issue && taken;
      branch_p1 <= issue && taken;
      wren_p1   <= issue && !ex.PC_load_IN && ex.wren_IN;
      write_p1  <= issue && !ex.PC_load_IN && ex.write_IN;
      if (issue) begin
        wad_p1   <= ex.writeAd_IN;
        admux_p1 <= ex.ADR_MUX_IN;
        store_p1 <= ex.opB_IN;
        if (ex.PC_load_IN) begin
          if (taken) result_p1 <= ex.opA_IN;
        end else if (ex.input_IN) begin
          result_p1 <= ex.ext_IN;
        end else begin
          result_p1 <= alu_o.res;
          flags_p1  <= alu_o.flg;
        end
      end
    end
  end

  assign ex.result_OUT    = result_p1;
  assign ex.storeData_OUT = store_p1;
  assign ex.wren_OUT      = wren_p1;
  assign ex.write_OUT     = write_p1;
  assign ex.ADR_MUX_OUT   = admux_p1;
  assign ex.writeAd_OUT   = wad_p1;
  assign ex.branch_OUT    = branch_p1;
  assign ex.flags_OUT     = flags_p1;
  assign ex.stall_OUT     = stall;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized
// instruction streams checked against an integer-arithmetic reference model.
module tb_execute_stage;
  localparam int W = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  execute_stage_if #(.DATA_W(W)) bus();
  execute_stage #(.DATA_W(W)) dut (.CLK(CLK), .RST(RST), .ex(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: flag register, pending squash, expected outputs.
  logic [3:0]   m_flags;
  logic         m_squash;
  logic [W-1:0] e_result, e_store;
  logic [2:0]   e_wad;
  logic         e_wren, e_write, e_branch, e_chk_res, e_chk_data;

  function automatic logic [W+3:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [3:0] f);
    longint modv, ua, ub, sa, sb, sr, r;
    int     n;
    logic   c, v;
    modv = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - modv : ua;
    sb = b[W-1] ? ub - modv : ub;
    n  = int'(b[3:0]);
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    case (op)
      3'd0: begin
        r  = (ua + ub) % modv;
        c  = (ua + ub) >= modv;
        sr = sa + sb;
        v  = (sr >= modv / 2) || (sr < -(modv / 2));
      end
      3'd1: begin
        r  = (ua - ub + modv) % modv;
        c  = ua >= ub;
        sr = sa - sb;
        v  = (sr >= modv / 2) || (sr < -(modv / 2));
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin
        r = (ua << n) % modv;
        c = (n != 0) && ((((ua << n) / modv) % 2) == 1);
        v = f[0];
      end
      3'd6: begin
        r = ua >> n;
        c = (n != 0) && (((ua >> (n - 1)) % 2) == 1);
        v = f[0];
      end
      default: r = ub;
    endcase
    return {r == 0, r >= modv / 2, c, v, r[W-1:0]};
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000; m_squash = 1'b0;
    e_result = '0; e_store = '0; e_wad = '0;
    e_wren = 1'b0; e_write = 1'b0; e_branch = 1'b0;
    e_chk_res = 1'b1; e_chk_data = 1'b1;
  endtask

  // Applies the architectural rules to the instruction presented at the upcoming edge.
  task automatic model_apply();
    logic [W+3:0] ar;
    logic         iss, tk;
    iss = bus.valid_IN && !m_squash;
    tk  = 1'b0;
    e_wren = 1'b0; e_write = 1'b0; e_branch = 1'b0;
    if (iss && bus.PC_load_IN) begin
      case (bus.cond_IN)
        3'd0: tk = 1'b1;
        3'd1: tk = m_flags[3];
        3'd2: tk = !m_flags[3];
        3'd3: tk = m_flags[2];
        3'd4: tk = !m_flags[2];
        3'd5: tk = m_flags[1];
        3'd6: tk = !m_flags[1];
        default: tk = m_flags[0];
      endcase
      e_chk_data = 1'b0;
      e_chk_res  = tk;
      if (tk) begin e_branch = 1'b1; e_result = bus.opA_IN; end
    end else if (iss) begin
      e_wren = bus.wren_IN; e_write = bus.write_IN;
      e_wad = bus.writeAd_IN; e_store = bus.opB_IN;
      e_chk_res = 1'b1; e_chk_data = 1'b1;
      if (bus.input_IN) e_result = bus.ext_IN;
      else begin
        ar = ref_alu(bus.op2_IN, bus.opA_IN, bus.opB_IN, m_flags);
        e_result = ar[W-1:0];
        m_flags  = ar[W+3:W];
      end
    end
    m_squash = iss && bus.PC_load_IN && tk;
  endtask

  task automatic set_instr(input logic v, input logic pcl, input logic inp, input logic wr,
                           input logic wm, input logic [2:0] wad, input logic [2:0] cond,
                           input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ext);
    bus.valid_IN = v; bus.PC_load_IN = pcl; bus.input_IN = inp; bus.wren_IN = wr;
    bus.write_IN = wm; bus.ADR_MUX_IN = wad[0]; bus.writeAd_IN = wad; bus.cond_IN = cond;
    bus.op2_IN = op; bus.opA_IN = a; bus.opB_IN = b; bus.ext_IN = ext;
  endtask

  task automatic set_random(input logic allow_branch);
    set_instr(($urandom_range(0, 9) != 0), allow_branch && ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), 3'($urandom),
              3'($urandom), 3'($urandom), W'($urandom), W'($urandom), W'($urandom));
  endtask

  // Holds inputs through any stall, then clocks the issuing edge; outputs sampled 1 after it.
  task automatic run_cycle(output int stalls, output bit tmo);
    stalls = 0;
    tmo    = 1'b0;
    #1;
    while (bus.stall_OUT === 1'b1 && !tmo) begin
      @(posedge CLK); #1;
      stalls++;
      if (stalls > 40) tmo = 1'b1;
    end
    model_apply();
    @(posedge CLK); #1;
  endtask

  task automatic idle_cycle();
    int st; bit tmo;
    set_instr(0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, '0, '0, '0);
    run_cycle(st, tmo);
  endtask

  task automatic test_reset();
    set_random(1'b1);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_tests++;
    if ({bus.result_OUT, bus.storeData_OUT} !== '0) begin
      n_fail++; $display("FAIL reset_data result=%h store=%h want 0", bus.result_OUT, bus.storeData_OUT);
    end
    n_tests++;
    if ({bus.wren_OUT, bus.write_OUT, bus.ADR_MUX_OUT, bus.writeAd_OUT, bus.branch_OUT} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0", {bus.wren_OUT, bus.write_OUT, bus.ADR_MUX_OUT, bus.writeAd_OUT, bus.branch_OUT});
    end
    n_tests++;
    if ({bus.flags_OUT, bus.stall_OUT} !== 5'd0) begin
      n_fail++; $display("FAIL reset_flags_stall flags=%b stall=%b want 0", bus.flags_OUT, bus.stall_OUT);
    end
    model_reset();
    RST = 1'b0;
    set_instr(0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, '0, '0, '0);
  endtask

  task automatic test_alu_directed();
    int st; bit tmo;
    set_instr(1, 0, 0, 1, 0, 3'd1, 3'd0, 3'b001, 16'h0005, 16'h0005, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.result_OUT, bus.flags_OUT} !== {16'h0000, 4'b1010}) begin
      n_fail++; $display("FAIL sub_eq result=%h flags=%b want 0000/1010", bus.result_OUT, bus.flags_OUT);
    end
    set_instr(1, 0, 0, 1, 0, 3'd2, 3'd0, 3'b000, 16'h7FFF, 16'h0001, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.result_OUT, bus.flags_OUT} !== {16'h8000, 4'b0101}) begin
      n_fail++; $display("FAIL add_ovf result=%h flags=%b want 8000/0101", bus.result_OUT, bus.flags_OUT);
    end
    set_instr(1, 0, 0, 1, 1, 3'd3, 3'd0, 3'b010, 16'hFFFF, 16'h00FF, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.result_OUT, bus.flags_OUT, bus.write_OUT} !== {16'h00FF, 4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL and_clr result=%h flags=%b write=%b want 00ff/0000/1", bus.result_OUT, bus.flags_OUT, bus.write_OUT);
    end
  endtask

  task automatic test_branch_squash();
    int st; bit tmo;
    set_instr(1, 0, 0, 0, 0, 3'd0, 3'd0, 3'b001, 16'h0005, 16'h0005, '0);
    run_cycle(st, tmo);
    set_instr(1, 1, 0, 1, 1, 3'd4, 3'b001, 3'b000, 16'h0040, 16'h0001, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.branch_OUT, bus.result_OUT, bus.wren_OUT, bus.write_OUT} !== {1'b1, 16'h0040, 2'b00}) begin
      n_fail++; $display("FAIL br_taken br=%b result=%h wren=%b write=%b want 1/0040/0/0", bus.branch_OUT, bus.result_OUT, bus.wren_OUT, bus.write_OUT);
    end
    set_instr(1, 0, 0, 1, 0, 3'd6, 3'd0, 3'b000, 16'h0001, 16'h0002, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.branch_OUT, bus.wren_OUT, bus.flags_OUT} !== {1'b0, 1'b0, 4'b1010}) begin
      n_fail++; $display("FAIL br_squash br=%b wren=%b flags=%b want 0/0/1010", bus.branch_OUT, bus.wren_OUT, bus.flags_OUT);
    end
    // Taken branch followed by an empty slot: the squash is consumed by the bubble.
    set_instr(1, 1, 0, 0, 0, 3'd0, 3'b000, 3'b000, 16'h0080, '0, '0);
    run_cycle(st, tmo);
    idle_cycle();
    set_instr(1, 0, 0, 1, 0, 3'd6, 3'd0, 3'b000, 16'h0001, 16'h0002, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.wren_OUT, bus.result_OUT, bus.writeAd_OUT} !== {1'b1, 16'h0003, 3'd6}) begin
      n_fail++; $display("FAIL squash_empty wren=%b result=%h wad=%0d want 1/0003/6", bus.wren_OUT, bus.result_OUT, bus.writeAd_OUT);
    end
    // A branch sitting in the squashed slot must not fire.
    set_instr(1, 1, 0, 0, 0, 3'd0, 3'b000, 3'b000, 16'h0080, '0, '0);
    run_cycle(st, tmo);
    set_instr(1, 1, 0, 0, 0, 3'd0, 3'b000, 3'b000, 16'h0099, '0, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.branch_OUT, bus.result_OUT} !== {1'b0, 16'h0080}) begin
      n_fail++; $display("FAIL br_in_slot br=%b result=%h want 0/0080", bus.branch_OUT, bus.result_OUT);
    end
  endtask

  task automatic test_not_taken();
    int st; bit tmo;
    set_instr(1, 0, 0, 0, 0, 3'd0, 3'd0, 3'b001, 16'h0005, 16'h0005, '0);
    run_cycle(st, tmo);
    set_instr(1, 1, 0, 0, 0, 3'd0, 3'b010, 3'b000, 16'h0040, '0, '0);
    run_cycle(st, tmo);
    n_tests++;
    if (bus.branch_OUT !== 1'b0) begin
      n_fail++; $display("FAIL br_not_taken br=%b want 0", bus.branch_OUT);
    end
    set_instr(1, 0, 0, 1, 0, 3'd2, 3'd0, 3'b000, 16'h0001, 16'h0002, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.wren_OUT, bus.result_OUT, bus.flags_OUT} !== {1'b1, 16'h0003, 4'b0000}) begin
      n_fail++; $display("FAIL after_not_taken wren=%b result=%h flags=%b want 1/0003/0000", bus.wren_OUT, bus.result_OUT, bus.flags_OUT);
    end
  endtask

  task automatic test_input_path();
    int st; bit tmo;
    set_instr(1, 0, 0, 0, 0, 3'd0, 3'd0, 3'b001, 16'h0005, 16'h0005, '0);
    run_cycle(st, tmo);
    set_instr(1, 0, 1, 1, 0, 3'd5, 3'd0, 3'b000, 16'h1234, 16'h00AA, 16'hBEEF);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.result_OUT, bus.writeAd_OUT, bus.wren_OUT, bus.flags_OUT, bus.ADR_MUX_OUT, bus.storeData_OUT}
        !== {16'hBEEF, 3'd5, 1'b1, 4'b1010, 1'b1, 16'h00AA}) begin
      n_fail++; $display("FAIL input_path result=%h wad=%0d wren=%b flags=%b amux=%b store=%h want beef/5/1/1010/1/00aa",
                         bus.result_OUT, bus.writeAd_OUT, bus.wren_OUT, bus.flags_OUT, bus.ADR_MUX_OUT, bus.storeData_OUT);
    end
  endtask

  task automatic test_shift();
    int st; bit tmo;
    set_instr(1, 0, 0, 1, 0, 3'd1, 3'd0, 3'b010, 16'h0000, 16'h0000, '0);
    run_cycle(st, tmo);
    set_instr(1, 0, 0, 1, 0, 3'd1, 3'd0, 3'b101, 16'h0001, 16'h0004, '0);
    run_cycle(st, tmo);
`ifdef EXEC_SERIAL_SHIFT_EN
    n_tests++;
    if ({st, tmo} !== {32'd3, 1'b0}) begin
      n_fail++; $display("FAIL sll_stall_cycles got %0d tmo=%b want 3", st, tmo);
    end
`else
    n_tests++;
    if (st !== 0) begin
      n_fail++; $display("FAIL sll_no_stall got %0d stall cycles want 0", st);
    end
`endif
    n_tests++;
    if ({bus.result_OUT, bus.flags_OUT, bus.wren_OUT} !== {16'h0010, 4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL sll4 result=%h flags=%b wren=%b want 0010/0000/1", bus.result_OUT, bus.flags_OUT, bus.wren_OUT);
    end
    set_instr(1, 0, 0, 1, 0, 3'd1, 3'd0, 3'b110, 16'h8001, 16'h0001, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.result_OUT, bus.flags_OUT} !== {16'h4000, 4'b0010}) begin
      n_fail++; $display("FAIL srl1 result=%h flags=%b want 4000/0010", bus.result_OUT, bus.flags_OUT);
    end
    set_instr(1, 0, 0, 1, 0, 3'd1, 3'd0, 3'b101, 16'h0003, 16'h000F, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.result_OUT, bus.flags_OUT, tmo} !== {16'h8000, 4'b0110, 1'b0}) begin
      n_fail++; $display("FAIL sll15 result=%h flags=%b tmo=%b want 8000/0110/0", bus.result_OUT, bus.flags_OUT, tmo);
    end
    set_instr(1, 0, 0, 1, 0, 3'd1, 3'd0, 3'b101, 16'h8000, 16'h0000, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.result_OUT, bus.flags_OUT} !== {16'h8000, 4'b0100}) begin
      n_fail++; $display("FAIL sll0 result=%h flags=%b want 8000/0100", bus.result_OUT, bus.flags_OUT);
    end
`ifdef EXEC_SERIAL_SHIFT_EN
    // Reset pulsed during the second stall cycle discards the partial shift.
    set_instr(1, 0, 0, 1, 0, 3'd2, 3'd0, 3'b101, 16'h0001, 16'h0004, '0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    n_tests++;
    if ({bus.result_OUT, bus.flags_OUT, bus.stall_OUT, bus.wren_OUT} !== '0) begin
      n_fail++; $display("FAIL rst_mid_shift result=%h flags=%b stall=%b wren=%b want 0", bus.result_OUT, bus.flags_OUT, bus.stall_OUT, bus.wren_OUT);
    end
    RST = 1'b0;
    model_reset();
    set_instr(0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, '0, '0, '0);
    @(posedge CLK); #1;
    n_tests++;
    if ({bus.result_OUT, bus.wren_OUT, bus.stall_OUT} !== '0) begin
      n_fail++; $display("FAIL rst_mid_shift_after result=%h wren=%b stall=%b want 0", bus.result_OUT, bus.wren_OUT, bus.stall_OUT);
    end
`endif
  endtask

  task automatic test_random_alu();
    int st; bit tmo, any_tmo;
    any_tmo = 1'b0;
    for (int i = 0; i < 60; i++) begin
      set_random(1'b0);
      run_cycle(st, tmo);
      any_tmo |= tmo;
      n_tests++;
      if ({bus.wren_OUT, bus.write_OUT, bus.branch_OUT, bus.flags_OUT} !== {e_wren, e_write, e_branch, m_flags}) begin
        n_fail++; $display("FAIL rand_ctrl[%0d] got %b want %b", i, {bus.wren_OUT, bus.write_OUT, bus.branch_OUT, bus.flags_OUT}, {e_wren, e_write, e_branch, m_flags});
      end
      n_tests++;
      if ({bus.result_OUT, bus.writeAd_OUT, bus.storeData_OUT} !== {e_result, e_wad, e_store}) begin
        n_fail++; $display("FAIL rand_data[%0d] result=%h wad=%0d store=%h want %h/%0d/%h", i, bus.result_OUT, bus.writeAd_OUT, bus.storeData_OUT, e_result, e_wad, e_store);
      end
    end
    n_tests++;
    if (any_tmo !== 1'b0) begin
      n_fail++; $display("FAIL rand_alu_timeout stall never released");
    end
  endtask

  task automatic test_back_to_back();
    int st; bit tmo, any_tmo;
    // Fresh flags from the ALU op feed the branch in the very next cycle.
    set_instr(1, 0, 0, 0, 0, 3'd0, 3'd0, 3'b001, 16'h0003, 16'h0007, '0);
    run_cycle(st, tmo);
    set_instr(1, 1, 0, 0, 0, 3'd0, 3'b011, 3'b000, 16'h1234, '0, '0);
    run_cycle(st, tmo);
    n_tests++;
    if ({bus.branch_OUT, bus.result_OUT, bus.flags_OUT} !== {1'b1, 16'h1234, 4'b0100}) begin
      n_fail++; $display("FAIL b2b_branch br=%b result=%h flags=%b want 1/1234/0100", bus.branch_OUT, bus.result_OUT, bus.flags_OUT);
    end
    any_tmo = 1'b0;
    for (int i = 0; i < 80; i++) begin
      set_random(1'b1);
      run_cycle(st, tmo);
      any_tmo |= tmo;
      n_tests++;
      if ({bus.wren_OUT, bus.write_OUT, bus.branch_OUT, bus.flags_OUT} !== {e_wren, e_write, e_branch, m_flags}) begin
        n_fail++; $display("FAIL b2b_ctrl[%0d] got %b want %b", i, {bus.wren_OUT, bus.write_OUT, bus.branch_OUT, bus.flags_OUT}, {e_wren, e_write, e_branch, m_flags});
      end
      if (e_chk_res) begin
        n_tests++;
        if (bus.result_OUT !== e_result) begin
          n_fail++; $display("FAIL b2b_result[%0d] got %h want %h", i, bus.result_OUT, e_result);
        end
      end
    end
    idle_cycle();
    n_tests++;
    if (any_tmo !== 1'b0) begin
      n_fail++; $display("FAIL b2b_timeout stall never released");
    end
  endtask

  initial begin
    set_instr(0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, '0, '0, '0);
    model_reset();
    test_reset();
    test_alu_directed();
    test_branch_squash();
    test_not_taken();
    test_input_path();
    test_shift();
    test_random_alu();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage fed directly by the decode-to-execute pipeline register. Consumes the registered decode control bundle plus two operands, performs the ALU operation selected by `op2_IN`, keeps the condition-flag register, resolves conditional branches against it, and registers a writeback/memory bundle for the next stage. Taken branches squash the single wrong-path instruction already in the decode register, and multi-bit shifts can optionally run serially with a stall back to upstream.

## Interface
- `DATA_W`, 16, operand/result width (≥ 8)
- `CLK`  in  1  clock, all state on rising edge
- `RST`  in  1  synchronous, active-high reset
- `valid_IN`  in  1  decode register holds a real instruction
- `input_IN`  in  1  result is `ext_IN` instead of the ALU output
- `wren_IN`  in  1  register-file write enable
- `writeAd_IN`  in  3  destination register
- `ADR_MUX_IN`  in  1  memory address source select, passed through
- `write_IN`  in  1  memory write
- `PC_load_IN`  in  1  instruction is a branch
- `cond_IN`  in  3  branch condition
- `op2_IN`  in  3  ALU operation
- `opA_IN`, `opB_IN`  in  DATA_W  operands; `opB_IN` is also store data
- `ext_IN`  in  DATA_W  external input port value
- `result_OUT`  out  DATA_W  registered result
- `storeData_OUT`  out  DATA_W  registered `opB_IN`
- `wren_OUT`, `write_OUT`, `ADR_MUX_OUT`  out  1  registered controls
- `writeAd_OUT`  out  3  registered destination
- `branch_OUT`  out  1  one-cycle pulse: taken branch, PC loads `opA_IN` (registered as `result_OUT`)
- `flags_OUT`  out  4  {Z,N,C,V} flag register
- `stall_OUT`  out  1  upstream must hold all inputs this cycle

## Operation
- Issue: `valid_IN=1`, `stall_OUT=0`, not squashed. Non-issued cycles register a bubble (`wren_OUT=write_OUT=branch_OUT=0`, other outputs hold).
- `op2_IN`: 000 A+B, 001 A−B, 010 A&B, 011 A|B, 100 A^B, 101 A<<B[3:0], 110 A>>B[3:0] (logical), 111 B.
- Arithmetic is modulo 2^DATA_W. ADD: C=carry-out. SUB: C=1 on no borrow (A≥B unsigned). V=signed overflow.
- Flags update on issued non-branch, `input_IN=0` instructions only. 000/001 update ZNCV. 010/011/100/111 update Z,N, and clear C,V. Shifts update Z,N and set C=last bit shifted out (0 when amount 0); V is unchanged.
- `input_IN=1`: result=`ext_IN`; flags unchanged.
- Branch (`PC_load_IN=1`): condition evaluated on the current flag register. Codes: 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 !C, 111 V.
  - Taken: `branch_OUT=1`, `result_OUT=opA_IN`.
  - Branches force `wren_OUT=write_OUT=0` and never change flags.
- Squash: the cycle after a taken-branch issue is squashed unconditionally, even if `valid_IN=0`. The squashed slot registers a bubble; a branch in it does not fire.
- Shift FSM (only with macro): IDLE → SHIFT → IDLE; see Configuration.

## Timing
- Reset: all outputs 0, flags 0000, FSM IDLE, squash pending cleared.
- Latency: issue at edge k → outputs valid after edge k+1, held until the next issue or bubble.
- Flags written at edge k+1 are seen by a branch issuing at edge k+1. Back-to-back ALU→branch therefore uses the fresh flags.
- `stall_OUT` is combinational from `valid_IN`/`op2_IN`/`opB_IN` in IDLE, and registered while in SHIFT.
- `RST` mid-shift: FSM returns to IDLE and the partial result is discarded. `stall_OUT=0` after the reset edge.

## Configuration
- `EXEC_SERIAL_SHIFT_EN` defined: a shift with amount n≥2 enters SHIFT and shifts 1 bit per cycle.
  - `stall_OUT=1` for exactly n−1 cycles starting in the issue cycle, while inputs are held.
  - Result, C and Z/N are registered n cycles after the first issue edge.
  - Amounts 0 and 1 complete in a single cycle with no stall.
- Not defined: single-cycle barrel shift; `stall_OUT` is tied 0 and the FSM is absent.

## Test plan
- Reset: assert `RST` for 2 cycles with random inputs → all outputs 0, `flags_OUT=0000`, `stall_OUT=0`.
- ALU/flags (DATA_W=16): SUB A=0x0005, B=0x0005 → result 0x0000, flags Z=1,N=0,C=1,V=0. ADD 0x7FFF+0x0001 → 0x8000, N=1,V=1,C=0.
- Branch/squash: SUB equal operands, then branch cond=001 with A=0x0040, then ADD with `wren_IN=1`.
  - Required: `branch_OUT` pulses once with `result_OUT=0x0040`; the ADD gives `wren_OUT=0` and flags are unchanged.
- Not-taken branch: cond=010 with Z=1 → `branch_OUT=0`, no squash; the following ADD writes normally.
- Input path: `input_IN=1`, `ext_IN=0xBEEF`, `wren_IN=1`, `writeAd_IN=5` → `result_OUT=0xBEEF`, `writeAd_OUT=5`, flags unchanged.
- Serial shift (macro on): SLL A=0x0001, B=4 → `stall_OUT` high 3 cycles, result 0x0010 four edges after issue. Repeat with `RST` pulsed in the second stall cycle → outputs 0, stall drops, no result written.
